// File: rtl/tron_pkg.sv
// Shared Tron types: game state codes, round/match winner codes and the start key.
package tron_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    PLAY      = 3'd1,
    ROUND_END = 3'd2,
    COUNTDOWN = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_RED  = 2'b01;
  localparam winner_t WIN_BLUE = 2'b10;
  localparam winner_t WIN_DRAW = 2'b11;

  localparam logic [7:0] START_KEY_ENTER = 8'h28;

  // Match winner by comparing final scores; equal scores are a draw.
  function automatic winner_t match_winner(input logic [1:0] red, input logic [1:0] blue);
    if (red > blue) return WIN_RED;
    if (blue > red) return WIN_BLUE;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame clock into the local domain and emits a
// registered one-cycle pulse per rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer; p2 holds the previous synchronized level
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
      tick    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Tron match sequencer: title, countdown, play, round-over and game-over
// screens, driven by frame ticks, the start key and per-round win flags.
module game_state_ctrl
  import tron_pkg::*;
#(
  parameter int         COUNTDOWN_FRAMES = 60,
  parameter int         ROUND_END_FRAMES = 120,
  parameter logic [1:0] WIN_SCORE        = 2'd3,
  parameter logic [7:0] START_KEY        = START_KEY_ENTER
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       Red_W,
  input  logic       Blue_W,
  input  logic [1:0] score_red,
  input  logic [1:0] score_blue,
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic       Round_Reset,
  output logic [1:0] Countdown,
  output logic [1:0] Winner
);

  localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > ROUND_END_FRAMES) ? COUNTDOWN_FRAMES
                                                                     : ROUND_END_FRAMES;
  localparam int FCNT_W = $clog2(MAX_FRAMES + 1);
  localparam logic [FCNT_W-1:0] CD_LAST = FCNT_W'(COUNTDOWN_FRAMES);
  localparam logic [FCNT_W-1:0] RE_LAST = FCNT_W'(ROUND_END_FRAMES);

  logic              frame_tick;
  logic              key_hit;
  logic              key_was_start_q;

  game_state_t       state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]        cd_q, cd_d;
  winner_t           winner_q, winner_d;
  logic              reset_score_q, reset_score_d;
  logic              round_reset_q, round_reset_d;

  frame_tick_sync u_frame_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .tick     (frame_tick)
  );

  // A held key yields one hit: only the first cycle it matches counts.
  assign key_hit = (keycode == START_KEY) && !key_was_start_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= TITLE;
      fcnt_q          <= '0;
      cd_q            <= 2'd0;
      winner_q        <= WIN_NONE;
      reset_score_q   <= 1'b1;
      round_reset_q   <= 1'b0;
      key_was_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      cd_q            <= cd_d;
      winner_q        <= winner_d;
      reset_score_q   <= reset_score_d;
      round_reset_q   <= round_reset_d;
      key_was_start_q <= (keycode == START_KEY);
    end
  end

  always_comb begin
    state_d       = state_q;
    fcnt_d        = frame_tick ? fcnt_q + FCNT_W'(1) : fcnt_q;
    cd_d          = cd_q;
    winner_d      = winner_q;
    reset_score_d = 1'b0;
    round_reset_d = 1'b0;

    case (state_q)
      TITLE: begin
        winner_d = WIN_NONE;
        cd_d     = 2'd0;
        if (key_hit) begin
          state_d       = COUNTDOWN;
          cd_d          = 2'd3;
          reset_score_d = 1'b1;
          round_reset_d = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (fcnt_q == CD_LAST) begin
          fcnt_d = '0;
          if (cd_q <= 2'd1) begin
            state_d = PLAY;
            cd_d    = 2'd0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      PLAY: begin
        // Both flags in one cycle encode as a draw (2'b11).
        if (Red_W || Blue_W) begin
          state_d  = ROUND_END;
          winner_d = {Blue_W, Red_W};
        end
      end
      ROUND_END: begin
        if (fcnt_q == RE_LAST) begin
          if (score_red >= WIN_SCORE || score_blue >= WIN_SCORE) begin
            state_d  = GAME_OVER;
            winner_d = match_winner(score_red, score_blue);
          end else begin
            state_d       = COUNTDOWN;
            cd_d          = 2'd3;
            winner_d      = WIN_NONE;
            round_reset_d = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (key_hit) begin
          state_d  = TITLE;
          winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d  = TITLE;
        cd_d     = 2'd0;
        winner_d = WIN_NONE;
      end
    endcase

    // Every state entry restarts frame counting and swallows a coincident tick.
    if (state_d != state_q) fcnt_d = '0;
  end

  assign Game_State  = state_q;
  assign Reset_Score = reset_score_q;
  assign Round_Reset = round_reset_q;
  assign Countdown   = cd_q;
  assign Winner      = winner_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized scoreboard bench for game_state_ctrl: stimulus tasks push the
// expected output snapshots, a forked monitor pops one per observed change.
module tb_game_state_ctrl;

  localparam int CF = 2;
  localparam int RE = 3;

  localparam int S_TITLE = 0;
  localparam int S_CD    = 1;
  localparam int S_PLAY  = 2;
  localparam int S_RE    = 3;
  localparam int S_GO    = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       Red_W = 1'b0;
  logic       Blue_W = 1'b0;
  logic [1:0] score_red = 2'd0;
  logic [1:0] score_blue = 2'd0;
  logic [2:0] Game_State;
  logic       Reset_Score;
  logic       Round_Reset;
  logic [1:0] Countdown;
  logic [1:0] Winner;

  game_state_ctrl #(
    .COUNTDOWN_FRAMES (CF),
    .ROUND_END_FRAMES (RE),
    .WIN_SCORE        (2'd3),
    .START_KEY        (8'h28)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .Red_W       (Red_W),
    .Blue_W      (Blue_W),
    .score_red   (score_red),
    .score_blue  (score_blue),
    .Game_State  (Game_State),
    .Reset_Score (Reset_Score),
    .Round_Reset (Round_Reset),
    .Countdown   (Countdown),
    .Winner      (Winner)
  );

  always #5 Clk = ~Clk;

  // Snapshot layout: {state[2:0], reset_score, round_reset, countdown[1:0], winner[1:0]}
  wire [8:0] cur_t = {Game_State, Reset_Score, Round_Reset, Countdown, Winner};

  logic [8:0] exp_q[$];
  logic [8:0] prev_t;
  logic [8:0] mon_exp;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  int m_state = S_TITLE;
  int m_ticks = 0;
  int m_digit = 0;
  int m_sr = 0;
  int m_sb = 0;

  function automatic logic [8:0] tup(input int gs, input int rs, input int rr,
                                     input int cd, input int w);
    return {gs[2:0], rs[0], rr[0], cd[1:0], w[1:0]};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clk);
      if (mon_en && cur_t !== prev_t) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h, required no change from %h (t=%0t)",
                   cur_t, prev_t, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cur_t !== mon_exp) begin
            n_fail++;
            $display("FAIL output_snapshot: got %h, required %h (t=%0t)", cur_t, mon_exp, $time);
          end
        end
        prev_t = cur_t;
      end
    end
  endtask

  task automatic drain(input int bound, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge Clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %h, required %h (%0d pending)",
               name, cur_t, exp_q[0], exp_q.size());
      exp_q.delete();
      prev_t = cur_t;
    end
    repeat (3) @(negedge Clk);
  endtask

  function automatic int match_w();
    if (m_sr > m_sb) return 1;
    if (m_sb > m_sr) return 2;
    return 3;
  endfunction

  task automatic release_key();
    logic [7:0] kc;
    kc = 8'($urandom_range(0, 255));
    if (kc == 8'h28) kc = 8'h00;
    keycode = kc;
  endtask

  task automatic press(input int hold);
    bool_start: begin end
    if (m_state == S_TITLE) begin
      exp_q.push_back(tup(3, 1, 1, 3, 0));
      exp_q.push_back(tup(3, 0, 0, 3, 0));
      m_state = S_CD;
      m_ticks = 0;
      m_digit = 3;
      m_sr = 0;
      m_sb = 0;
    end else if (m_state == S_GO) begin
      exp_q.push_back(tup(0, 0, 0, 0, 0));
      m_state = S_TITLE;
    end
    @(posedge Clk);
    #1;
    keycode = 8'h28;
    score_red = 2'(m_sr);
    score_blue = 2'(m_sb);
    drain(3, "key_hit");
    repeat (hold) @(posedge Clk);
    #1;
    release_key();
    repeat (2) @(negedge Clk);
  endtask

  task automatic win(input int r, input int b, input int nsr, input int nsb);
    bit live;
    live = (m_state == S_PLAY);
    if (live) begin
      exp_q.push_back(tup(2, 0, 0, 0, (b << 1) | r));
      m_state = S_RE;
      m_ticks = 0;
      m_sr = nsr;
      m_sb = nsb;
    end
    @(posedge Clk);
    #1;
    Red_W = r[0];
    Blue_W = b[0];
    if (live) begin
      score_red = 2'(nsr);
      score_blue = 2'(nsb);
    end
    @(posedge Clk);
    #1;
    Red_W = 1'b0;
    Blue_W = 1'b0;
    drain(2, "round_win");
  endtask

  task automatic frame();
    if (m_state == S_CD) begin
      m_ticks++;
      if (m_ticks == CF) begin
        m_ticks = 0;
        m_digit--;
        if (m_digit == 0) begin
          exp_q.push_back(tup(1, 0, 0, 0, 0));
          m_state = S_PLAY;
        end else begin
          exp_q.push_back(tup(3, 0, 0, m_digit, 0));
        end
      end
    end else if (m_state == S_RE) begin
      m_ticks++;
      if (m_ticks == RE) begin
        if (m_sr >= 3 || m_sb >= 3) begin
          exp_q.push_back(tup(4, 0, 0, 0, match_w()));
          m_state = S_GO;
        end else begin
          exp_q.push_back(tup(3, 0, 1, 3, 0));
          exp_q.push_back(tup(3, 0, 0, 3, 0));
          m_state = S_CD;
          m_ticks = 0;
          m_digit = 3;
        end
      end
    end
    @(posedge Clk);
    #2 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #2 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    drain(4, "frame");
  endtask

  task automatic random_round_win();
    int kind, r, b;
    kind = $urandom_range(0, 2);
    r = (kind != 1) ? 1 : 0;
    b = (kind != 0) ? 1 : 0;
    win(r, b, (m_sr + r > 3) ? 3 : m_sr + r, (m_sb + b > 3) ? 3 : m_sb + b);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values while Reset_n is held low
    #1 Reset_n = 1'b0;
    #2;
    chk("reset_game_state", Game_State, 0);
    chk("reset_reset_score", Reset_Score, 1);
    chk("reset_round_reset", Round_Reset, 0);
    chk("reset_countdown", Countdown, 0);
    chk("reset_winner", Winner, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    prev_t = tup(0, 1, 0, 0, 0);
    exp_q.push_back(tup(0, 0, 0, 0, 0));
    mon_en = 1'b1;
    Reset_n = 1'b1;
    #1 chk("reset_score_until_edge", Reset_Score, 1);
    drain(2, "reset_release");

    // Ignored win flag in TITLE, then start with the key held 10 cycles
    win(0, 1, 0, 0);
    press(10);
    frame();
    frame();
    win(0, 1, 0, 0);
    repeat (4) frame();
    press(3);

    // Red wins, round over, next countdown
    win(1, 0, 1, 0);
    repeat (3) frame();
    repeat (6) frame();
    // Draw round
    win(1, 1, 2, 1);
    repeat (3) frame();
    repeat (6) frame();
    // Blue reaches the winning score
    win(0, 1, 2, 3);
    repeat (3) frame();
    press(2);

    // Asynchronous reset in the middle of ROUND_END
    press(2);
    repeat (6) frame();
    win(1, 0, 1, 0);
    frame();
    mon_en = 1'b0;
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("midreset_game_state", Game_State, 0);
    chk("midreset_winner", Winner, 0);
    chk("midreset_reset_score", Reset_Score, 1);
    exp_q.delete();
    m_state = S_TITLE;
    m_sr = 0;
    m_sb = 0;
    score_red = 2'd0;
    score_blue = 2'd0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    prev_t = tup(0, 1, 0, 0, 0);
    exp_q.push_back(tup(0, 0, 0, 0, 0));
    mon_en = 1'b1;
    Reset_n = 1'b1;
    drain(2, "midreset_release");
    press(2);
    repeat (6) frame();

    // Randomized play driven by the reference model's current screen
    for (int i = 0; i < 220; i++) begin
      int p;
      p = $urandom_range(0, 99);
      case (m_state)
        S_TITLE: if (p < 70) press($urandom_range(1, 12));
                 else if (p < 85) win($urandom_range(0, 1), 1, m_sr, m_sb);
                 else frame();
        S_CD:    if (p < 80) frame();
                 else if (p < 90) win(1, $urandom_range(0, 1), m_sr, m_sb);
                 else press($urandom_range(1, 5));
        S_PLAY:  if (p < 60) random_round_win();
                 else if (p < 80) frame();
                 else press($urandom_range(1, 5));
        S_RE:    if (p < 85) frame();
                 else if (p < 93) win(1, 1, m_sr, m_sb);
                 else press($urandom_range(1, 5));
        default: if (p < 60) press($urandom_range(1, 12));
                 else if (p < 80) frame();
                 else win(0, 1, m_sr, m_sb);
      endcase
    end

    drain(10, "final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level Tron game sequencer, directly downstream of the `score` block. It consumes `score`'s per-round win flags (`Red_W`, `Blue_W`) and running scores. It produces the `Game_State` code and the `Reset_Score` pulse that `score` depends on, plus a round-restart pulse for the bike/trail logic and a countdown digit for the display. All timing is in frames, derived from `frame_clk`, and the block itself runs on the 50 MHz `Clk`.

## Interface
- `COUNTDOWN_FRAMES`, default 60: frames per countdown digit.
- `ROUND_END_FRAMES`, default 120: frames the round-over screen is held.
- `WIN_SCORE`, default 2'd3: score that ends the match.
- `START_KEY`, default 8'h28: keycode (Enter) that starts or acknowledges.

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: one clock; reset is asynchronous and active-low.
- `frame_clk` in 1: ~60 Hz frame clock, asynchronous to `Clk`.
- `keycode` in 8: current USB keycode, level.
- `Red_W` in 1: red won the round; one-`Clk` pulse from `score`.
- `Blue_W` in 1: blue won the round; one-`Clk` pulse from `score`.
- `score_red` in 2: red running score from `score`.
- `score_blue` in 2: blue running score from `score`.
- `Game_State` out 3: current state code.
- `Reset_Score` out 1: active-high clear to `score`.
- `Round_Reset` out 1: one-`Clk` pulse that restarts bikes and trails.
- `Countdown` out 2: digit to display (3..1); 0 outside COUNTDOWN.
- `Winner` out 2: 00 none, 01 red, 10 blue, 11 draw.

## Operation
- `Game_State` encoding:
  - TITLE = 0
  - PLAY = 1
  - ROUND_END = 2
  - COUNTDOWN = 3
  - GAME_OVER = 4
  - Codes 5–7 are unreachable; if entered, recover to TITLE on the next edge.
- frame_tick: `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detect.
  - It is a registered one-`Clk` pulse, one per frame.
- key_hit: asserted when `keycode == START_KEY` and the previous registered `keycode` was not `START_KEY`.
  - Holding the key yields exactly one key_hit.
- Frame counter `fcnt`: width `$clog2(max(COUNTDOWN_FRAMES, ROUND_END_FRAMES)+1)`.
  - Cleared on every state entry.
  - Increments on frame_tick.
- TITLE:
  - On key_hit go to COUNTDOWN.
  - Pulse `Reset_Score` and `Round_Reset` for one cycle each.
  - Set `Winner` = 00.
- COUNTDOWN:
  - `Countdown` = 3 on entry.
  - When `fcnt` reaches `COUNTDOWN_FRAMES`, decrement `Countdown` and clear `fcnt`.
  - A decrement from 1 goes to PLAY with `Countdown` = 0.
  - Total duration is exactly 3·`COUNTDOWN_FRAMES` frame_ticks.
- PLAY, on `Red_W` and/or `Blue_W` go to ROUND_END and latch `Winner`:
  - `Red_W` only: 01.
  - `Blue_W` only: 10.
  - Both in the same cycle: 11.
- ROUND_END:
  - Hold until `fcnt` == `ROUND_END_FRAMES`.
  - Then, if `score_red` ≥ `WIN_SCORE` or `score_blue` ≥ `WIN_SCORE`, go to GAME_OVER.
  - Otherwise go to COUNTDOWN, pulse `Round_Reset` and clear `Winner`.
- GAME_OVER:
  - `Winner` shows the match winner: 01/10 by higher score, 11 if equal.
  - On key_hit go to TITLE.
- Ignored inputs:
  - `Red_W`/`Blue_W` outside PLAY.
  - key_hit outside TITLE and GAME_OVER.
- `Reset_Score` is high only during reset or in the TITLE→COUNTDOWN pulse cycle.

## Timing
- Reset values:
  - `Game_State` = TITLE.
  - `Reset_Score` = 1; it deasserts on the first `Clk` edge after `Reset_n` rises.
  - `Round_Reset` = 0.
  - `Countdown` = 0.
  - `Winner` = 00.
  - `fcnt` = 0, synchronizer flops = 0.
- Latencies:
  - `Red_W`/`Blue_W`/key_hit-driven transitions occur on the next `Clk` edge.
  - `Reset_Score`/`Round_Reset` are asserted in the first cycle of the new state.
  - frame_clk rise → frame_tick high after 3 `Clk` edges; the counter or state update lands on the 4th.
- Simultaneous events:
  - frame_tick in the same cycle as a state transition is consumed by the transition; `fcnt` stays 0.
  - key_hit together with a reset assertion: reset wins.
- Mid-operation reset:
  - Asynchronous `Reset_n` low forces the reset values immediately, in any state.
  - No pulse is left half-emitted.

## Structure
- Shared package `tron_pkg`: `game_state_t` enum (codes above), `winner_t` (2-bit), `START_KEY_ENTER` constant.
  - `score` and the display also import `tron_pkg`.
- Sub-module `frame_tick_sync`: 2-flop synchronizer plus registered rising-edge pulse, with the same async active-low reset.
  - Reusable by other frame-timed blocks.

## Test plan
- Reset and start:
  - `Reset_n` low, then high → `Game_State` = 0 and `Reset_Score` = 1 until the first edge, then 0.
  - `keycode` = 28h held for 10 cycles → exactly one `Reset_Score` pulse, one `Round_Reset` pulse, and `Game_State` = 3.
- Countdown (`COUNTDOWN_FRAMES` = 2):
  - 6 `frame_clk` periods → `Countdown` reads 3,3,2,2,1,1.
  - `Game_State` = 1 after the 6th frame_tick, with `Countdown` = 0.
- Round win:
  - In PLAY, `Red_W` pulse with `score_red` = 1 → `Game_State` = 2 and `Winner` = 01.
  - After `ROUND_END_FRAMES` ticks → `Game_State` = 3 with a `Round_Reset` pulse.
- Draw and match end:
  - `Red_W` and `Blue_W` in the same cycle → `Winner` = 11.
  - Next round `Blue_W` with `score_blue` = 3 → after ROUND_END, `Game_State` = 4 and `Winner` = 10.
  - key_hit → `Game_State` = 0.
- Ignored events:
  - `Blue_W` during COUNTDOWN or TITLE → no state change.
  - `keycode` = 28h during PLAY → no change.
- Async reset mid-ROUND_END:
  - `Reset_n` low between `Clk` edges → `Game_State` = 0, `Winner` = 00 and `Reset_Score` = 1 immediately.
  - `fcnt` restarts from 0.
